lifo_stack: RTL and testbench

LIFO_STACK -- requirements
Module: lifo_stack

---
 rtl/lifo_stack_pkg.sv | 38 +++
 rtl/lifo_stack.sv | 102 ++++++++++
 tb/tb_lifo_stack.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/lifo_stack_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lifo_stack_pkg
//  Description : Shared types for the LIFO stack. Decodes the two strobes
//                plus the current fill state into the single operation that
//                the stack performs on a given clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
package lifo_stack_pkg;

    typedef enum logic [1:0] {
        OP_IDLE    = 2'd0,   // nothing changes
        OP_PUSH    = 2'd1,   // write above top, grow by one
        OP_POP     = 2'd2,   // shrink by one
        OP_REPLACE = 2'd3    // overwrite top in place, depth unchanged
    } op_e;

    // Operation selected by the strobes for the current state.
    // A combined push+pop on an empty stack has no top to replace, so it
    // degenerates to a plain push (DEPTH >= 2 guarantees empty implies not full).
    function automatic op_e decode_op(input logic push,
                                      input logic pop,
                                      input logic empty,
                                      input logic full);
        op_e op;
        op = OP_IDLE;
        if (push && pop) begin
            op = empty ? OP_PUSH : OP_REPLACE;
        end else if (push) begin
            op = full ? OP_IDLE : OP_PUSH;
        end else if (pop) begin
            op = empty ? OP_IDLE : OP_POP;
        end
        return op;
    endfunction

endpackage : lifo_stack_pkg
`default_nettype wire

// File: rtl/lifo_stack.sv
`default_nettype none
// ============================================================================
//  Module      : lifo_stack
//  Description : Register-based LIFO stack of DEPTH words of WIDTH bits.
//                Top-of-stack is presented combinationally on POP_DAT.
//  Ports       : CLK      - clock, rising edge active
//                RST_N    - asynchronous active-low reset
//                PUSH_STB - push request
//                PUSH_DAT - data to push
//                POP_STB  - pop request
//                POP_DAT  - current top-of-stack (zero when empty)
//                EMPTY    - no entries stored
//                FULL     - DEPTH entries stored
//                COUNT    - number of stored entries
//  Revision    : 1.0 - initial release
// ============================================================================
module lifo_stack
    import lifo_stack_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 20
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         PUSH_STB,
    input  logic [WIDTH-1:0]             PUSH_DAT,
    input  logic                         POP_STB,
    output logic [WIDTH-1:0]             POP_DAT,
    output logic                         EMPTY,
    output logic                         FULL,
    output logic [$clog2(DEPTH+1)-1:0]   COUNT
);

    localparam int C_CW = $clog2(DEPTH + 1);              // pointer width, 0..DEPTH
    localparam int C_IW = (DEPTH > 1) ? $clog2(DEPTH) : 1; // storage index width

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [C_CW-1:0]  r_sp;

    logic             w_empty;
    logic             w_full;
    logic [C_IW-1:0]  w_top_idx;
    logic [C_IW-1:0]  w_wr_idx;
    logic             w_wr_en;
    op_e              w_op;

    assign w_empty   = (r_sp == '0);
    assign w_full    = (r_sp == C_CW'(DEPTH));
    // Only meaningful while r_sp > 0; the output mux masks the empty case.
    assign w_top_idx = C_IW'(r_sp - C_CW'(1));
    assign w_op      = decode_op(PUSH_STB, POP_STB, w_empty, w_full);

    // A push writes the first free slot, a replace overwrites the top.
    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_idx = '0;
        case (w_op)
            OP_PUSH: begin
                w_wr_en  = 1'b1;
                w_wr_idx = C_IW'(r_sp);
            end
            OP_REPLACE: begin
                w_wr_en  = 1'b1;
                w_wr_idx = w_top_idx;
            end
            default: begin
                w_wr_en  = 1'b0;
                w_wr_idx = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sp <= '0;
        end else begin
            case (w_op)
                OP_PUSH: r_sp <= r_sp + C_CW'(1);
                OP_POP:  r_sp <= r_sp - C_CW'(1);
                default: r_sp <= r_sp;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[w_wr_idx] <= PUSH_DAT;
        end
    end

    // Stale entries above the pointer are never exposed.
    assign POP_DAT = w_empty ? '0 : r_mem[w_top_idx];
    assign EMPTY   = w_empty;
    assign FULL    = w_full;
    assign COUNT   = r_sp;

endmodule : lifo_stack
`default_nettype wire

// File: tb/tb_lifo_stack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lifo_stack
//  Description : Self-checking bench for lifo_stack (WIDTH=32, DEPTH=20).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lifo_stack;

    localparam int C_WIDTH = 32;
    localparam int C_DEPTH = 20;
    localparam int C_CW    = $clog2(C_DEPTH + 1);

    logic               CLK;
    logic               RST_N;
    logic               PUSH_STB;
    logic [C_WIDTH-1:0] PUSH_DAT;
    logic               POP_STB;
    logic [C_WIDTH-1:0] POP_DAT;
    logic               EMPTY;
    logic               FULL;
    logic [C_CW-1:0]    COUNT;

    int n_checks = 0;
    int n_fail   = 0;

    lifo_stack #(
        .WIDTH (C_WIDTH),
        .DEPTH (C_DEPTH)
    ) u_dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .PUSH_STB (PUSH_STB),
        .PUSH_DAT (PUSH_DAT),
        .POP_STB  (POP_STB),
        .POP_DAT  (POP_DAT),
        .EMPTY    (EMPTY),
        .FULL     (FULL),
        .COUNT    (COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic               push;
        logic               pop;
        logic [C_WIDTH-1:0] dat;
        int                 cnt;
        logic [C_WIDTH-1:0] top;
    } vec_t;

    function automatic vec_t mk(input logic push, input logic pop,
                                input logic [C_WIDTH-1:0] dat,
                                input int cnt, input logic [C_WIDTH-1:0] top);
        vec_t v;
        v.push = push; v.pop = pop; v.dat = dat; v.cnt = cnt; v.top = top;
        return v;
    endfunction

    task automatic chk(input string name, input logic [C_WIDTH-1:0] act,
                       input logic [C_WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Full state check against an expected count and top value.
    task automatic chk_state(input string tag, input int cnt,
                             input logic [C_WIDTH-1:0] top);
        chk({tag, ".count"}, C_WIDTH'(COUNT), C_WIDTH'(cnt));
        chk({tag, ".top"},   POP_DAT, top);
        chk({tag, ".empty"}, C_WIDTH'(EMPTY), C_WIDTH'(cnt == 0));
        chk({tag, ".full"},  C_WIDTH'(FULL),  C_WIDTH'(cnt == C_DEPTH));
    endtask

    // Apply strobes for one edge; outputs sampled 1 time unit after it.
    task automatic step(input logic push, input logic pop,
                        input logic [C_WIDTH-1:0] dat);
        PUSH_STB = push;
        POP_STB  = pop;
        PUSH_DAT = dat;
        @(posedge CLK);
        #1;
        PUSH_STB = 1'b0;
        POP_STB  = 1'b0;
        PUSH_DAT = 32'hDEAD_BEEF;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    vec_t vecs[20];

    initial begin
        RST_N    = 1'b0;
        PUSH_STB = 1'b0;
        POP_STB  = 1'b0;
        PUSH_DAT = '0;

        // Sequence covering basic push/pop, empty pop, RPN, replace.
        vecs[0]  = mk(1, 0, 32'd5,  1, 32'd5);
        vecs[1]  = mk(1, 0, 32'd7,  2, 32'd7);
        vecs[2]  = mk(1, 0, 32'd9,  3, 32'd9);
        vecs[3]  = mk(0, 1, 32'd0,  2, 32'd7);
        vecs[4]  = mk(0, 1, 32'd0,  1, 32'd5);
        vecs[5]  = mk(0, 1, 32'd0,  0, 32'd0);
        vecs[6]  = mk(0, 1, 32'd0,  0, 32'd0);      // pop on empty ignored
        vecs[7]  = mk(1, 1, 32'hA5, 1, 32'hA5);     // push+pop on empty = push
        vecs[8]  = mk(0, 1, 32'd0,  0, 32'd0);
        vecs[9]  = mk(1, 0, 32'hA5, 1, 32'hA5);
        vecs[10] = mk(0, 1, 32'd0,  0, 32'd0);
        vecs[11] = mk(1, 0, 32'd3,  1, 32'd3);      // RPN: 3 4
        vecs[12] = mk(1, 0, 32'd4,  2, 32'd4);
        vecs[13] = mk(0, 1, 32'd0,  1, 32'd3);
        vecs[14] = mk(0, 1, 32'd0,  0, 32'd0);
        vecs[15] = mk(1, 0, 32'd12, 1, 32'd12);
        vecs[16] = mk(1, 0, 32'd8,  2, 32'd8);
        vecs[17] = mk(1, 1, 32'h55, 2, 32'h55);     // replace top
        vecs[18] = mk(0, 0, 32'hFF, 2, 32'h55);     // idle holds
        vecs[19] = mk(0, 1, 32'd0,  1, 32'd12);

        // Asynchronous reset state, checked before any clock edge.
        #2;
        chk_state("reset", 0, 32'd0);
        do_reset();
        chk_state("post_reset", 0, 32'd0);

        for (int i = 0; i < 20; i++) begin
            step(vecs[i].push, vecs[i].pop, vecs[i].dat);
            chk_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].top);
        end

        // Fill to DEPTH and attempt one more push.
        do_reset();
        for (int v = 1; v <= 21; v++) begin
            step(1'b1, 1'b0, C_WIDTH'(v));
            if (v == 19) chk_state("fill19", 19, 32'd19);
        end
        chk_state("full", C_DEPTH, 32'd20);
        step(1'b1, 1'b1, 32'h77);                     // replace while full
        chk_state("full_replace", C_DEPTH, 32'h77);
        step(1'b0, 1'b1, 32'd0);
        chk_state("pop_after_full", 19, 32'd19);
        for (int k = 0; k < 18; k++) step(1'b0, 1'b1, 32'd0);
        chk_state("drain_to_1", 1, 32'd1);

        // Asynchronous reset between edges with 4 entries stored.
        do_reset();
        for (int v = 1; v <= 4; v++) step(1'b1, 1'b0, C_WIDTH'(v * 16));
        chk_state("four", 4, 32'd64);
        #2;
        RST_N = 1'b0;
        #1;
        chk_state("async_rst", 0, 32'd0);

        // Strobe held through reset; first push lands at the first edge after release.
        PUSH_STB = 1'b1;
        PUSH_DAT = 32'h1234;
        @(posedge CLK);
        #1;
        chk_state("rst_hold", 0, 32'd0);
        #2;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        chk_state("rst_release", 1, 32'h1234);
        @(posedge CLK);
        #1;
        PUSH_STB = 1'b0;
        chk_state("held_strobe", 2, 32'h1234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_lifo_stack
`default_nettype wire
